// File: rtl/md_unit_if.sv
// Issue/result bundle between the EX stage and the multiply/divide unit.
// The EX stage is the master; md_unit is the slave and owns HI/LO.
interface md_unit_if;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] valA;
    logic [31:0] valB;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, md_op, valA, valB, flush,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, md_op, valA, valB, flush,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/md_unit.sv
// Iterative 32-cycle multiply/divide unit holding the HI/LO registers.
// The multiply is radix-2 shift-add and the divide is restoring shift-subtract.
// Both run on magnitudes, and the signs are applied on the final edge.
module md_unit (
    input logic        clk,
    input logic        rst_n,
    md_unit_if.slave   bus
);
    typedef enum logic {Idle, Run} stateT;

    stateT       stateQ, stateD;
    logic        isDiv;      // latched op: divide vs multiply
    logic        negRes;     // product / quotient must be negated
    logic        negRem;     // remainder takes the dividend's sign
    logic        divZero;    // divisor was zero at issue
    logic [31:0] origA;      // raw dividend for the divide-by-zero result
    logic [31:0] opB;        // multiplicand (mult) or divisor (div) magnitude
    logic [63:0] acc;        // mult: {partial, multiplier}; div: low half = dividend/quotient
    logic [32:0] rem;
    logic [5:0]  cnt;
    logic [31:0] hiReg, loReg;
    logic        doneReg;

    logic        issue, issueMd, lastStep;
    logic        opSigned;
    logic [31:0] absA, absB;
    logic [32:0] mulSum;
    logic [63:0] mulNext, prod;
    logic [32:0] divShift;
    logic [33:0] divDiff;
    logic        divGe;
    logic [32:0] divRemNext;
    logic [31:0] divQNext, quot, remOut;
    logic [31:0] resHi, resLo;

    assign issue    = (stateQ == Idle) && bus.start && !bus.flush;
    assign issueMd  = issue && !bus.md_op[2];
    assign lastStep = (stateQ == Run) && (cnt == 6'd31);

    // Magnitudes for the issue cycle. MULT and DIV are the even opcodes.
    always_comb begin
        opSigned = !bus.md_op[0];
        absA     = (opSigned && bus.valA[31]) ? (32'd0 - bus.valA) : bus.valA;
        absB     = (opSigned && bus.valB[31]) ? (32'd0 - bus.valB) : bus.valB;
    end

    // One iteration of each algorithm, and the signed result of the final iteration.
    always_comb begin
        mulSum     = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opB} : 33'd0);
        mulNext    = {mulSum, acc[31:1]};
        divShift   = {rem[31:0], acc[31]};
        divDiff    = {1'b0, divShift} - {2'b00, opB};
        divGe      = !divDiff[33];
        divRemNext = divGe ? divDiff[32:0] : divShift;
        divQNext   = {acc[30:0], divGe};
        prod       = negRes ? (64'd0 - mulNext) : mulNext;
        quot       = negRes ? (32'd0 - divQNext) : divQNext;
        remOut     = negRem ? (32'd0 - divRemNext[31:0]) : divRemNext[31:0];
        if (!isDiv) begin
            resHi = prod[63:32];
            resLo = prod[31:0];
        end else if (divZero) begin
            resHi = origA;
            resLo = 32'hFFFF_FFFF;
        end else begin
            resHi = remOut;
            resLo = quot;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stateQ <= Idle;
        else        stateQ <= stateD;
    end

    // Next state: flush wins over everything, and RUN ends after 32 iterations.
    always_comb begin
        stateD = stateQ;
        unique case (stateQ)
            Idle: if (issueMd) stateD = Run;
            Run:  if (bus.flush || lastStep) stateD = Idle;
            default: stateD = Idle;
        endcase
    end

    // Operand latch, iteration datapath and HI/LO writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            isDiv   <= 1'b0;
            negRes  <= 1'b0;
            negRem  <= 1'b0;
            divZero <= 1'b0;
            origA   <= 32'd0;
            opB     <= 32'd0;
            acc     <= 64'd0;
            rem     <= 33'd0;
            cnt     <= 6'd0;
            hiReg   <= 32'd0;
            loReg   <= 32'd0;
            doneReg <= 1'b0;
        end else begin
            doneReg <= 1'b0;
            if (issue) begin
                case (bus.md_op)
                    3'd0, 3'd1, 3'd2, 3'd3: begin
                        isDiv   <= bus.md_op[1];
                        negRes  <= opSigned && (bus.valA[31] ^ bus.valB[31]);
                        negRem  <= opSigned && bus.valA[31];
                        divZero <= (bus.valB == 32'd0);
                        origA   <= bus.valA;
                        rem     <= 33'd0;
                        cnt     <= 6'd0;
                        if (bus.md_op[1]) begin
                            opB <= absB;
                            acc <= {32'd0, absA};
                        end else begin
                            opB <= absA;
                            acc <= {32'd0, absB};
                        end
                    end
                    3'd4:    hiReg <= bus.valA;
                    3'd5:    loReg <= bus.valA;
                    default: ;
                endcase
            end else if ((stateQ == Run) && !bus.flush) begin
                acc <= isDiv ? {acc[63:32], divQNext} : mulNext;
                rem <= isDiv ? divRemNext : rem;
                cnt <= cnt + 6'd1;
                if (lastStep) begin
                    hiReg   <= resHi;
                    loReg   <= resLo;
                    doneReg <= 1'b1;
                end
            end
        end
    end

    assign bus.busy = (stateQ == Run);
    assign bus.done = doneReg;
    assign bus.hi   = hiReg;
    assign bus.lo   = loReg;
endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: a vector table plus hand-written corner sequences.
// Expected HI/LO go into a scoreboard queue at issue and are checked on done.
module tb_md_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    md_unit_if bus ();

    md_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expHi;
        logic [31:0] expLo;
        string       name;
    } vecT;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } expT;

    expT sb[$];
    vecT vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge: drives a start for this cycle (T) and returns at the negedge of T+1.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.md_op = op;
        bus.valA  = a;
        bus.valB  = b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.valA  = 32'h5A5A_A5A5;
        bus.valB  = 32'hA5A5_5A5A;
    endtask

    // Entered at negedge T+1. Waits (bounded) for done, poking ignored starts at cycles pA/pB.
    task automatic waitDone(input string name, input int pA, input int pB);
        int  k = 1;
        int  busyCnt = 0;
        bit  seen = 0;
        expT e;
        while (k <= 40 && !seen) begin
            if (k == pA || k == pB) begin
                bus.start = 1'b1;
                bus.md_op = 3'd2;
                bus.valA  = 32'd100;
                bus.valB  = 32'd3;
            end else begin
                bus.start = 1'b0;
            end
            if (bus.done) seen = 1;
            else begin
                if (bus.busy) busyCnt++;
                @(negedge clk);
                k++;
            end
        end
        bus.start = 1'b0;
        check({name, " latency"}, k, 33);
        check({name, " busy cycles"}, busyCnt, 32);
        check({name, " busy at done"}, {31'd0, bus.busy}, 32'd0);
        if (sb.size() == 0) begin
            check({name, " scoreboard empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check({name, " hi"}, bus.hi, e.hi);
            check({name, " lo"}, bus.lo, e.lo);
        end
        @(negedge clk);
        check({name, " done single pulse"}, {31'd0, bus.done}, 32'd0);
    endtask

    task automatic runOp(input vecT v);
        expT e;
        e.hi = v.expHi;
        e.lo = v.expLo;
        sb.push_back(e);
        issue(v.op, v.a, v.b);
        waitDone(v.name, 0, 0);
    endtask

    initial begin
        expT e;
        vecs[0] = '{3'd0, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA, "mult -2x3"};
        vecs[1] = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu max"};
        vecs[2] = '{3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div -7/2"};
        vecs[3] = '{3'd3, 32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0001, 32'h7FFF_FFFC, "divu"};
        vecs[4] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, "div ovf"};
        vecs[5] = '{3'd3, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFF, "divu by 0"};
        vecs[6] = '{3'd2, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, "div by 0"};
        vecs[7] = '{3'd2, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, "div 7/-2"};
        vecs[8] = '{3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, "mult minsq"};
        vecs[9] = '{3'd1, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780, "multu x16"};

        bus.start = 1'b0;
        bus.md_op = 3'd0;
        bus.valA  = 32'd0;
        bus.valB  = 32'd0;
        bus.flush = 1'b0;
        repeat (2) @(negedge clk);
        check("reset busy", {31'd0, bus.busy}, 32'd0);
        check("reset done", {31'd0, bus.done}, 32'd0);
        check("reset hi", bus.hi, 32'd0);
        check("reset lo", bus.lo, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) runOp(vecs[i]);

        // MTHI then MTLO on consecutive cycles.
        bus.start = 1'b1;
        bus.md_op = 3'd4;
        bus.valA  = 32'hDEAD_BEEF;
        @(negedge clk);
        check("mthi hi", bus.hi, 32'hDEAD_BEEF);
        check("mthi busy", {31'd0, bus.busy}, 32'd0);
        bus.md_op = 3'd5;
        bus.valA  = 32'h0BAD_F00D;
        @(negedge clk);
        bus.start = 1'b0;
        check("mtlo lo", bus.lo, 32'h0BAD_F00D);
        check("mtlo hi kept", bus.hi, 32'hDEAD_BEEF);
        check("mtlo busy", {31'd0, bus.busy}, 32'd0);
        check("mt done", {31'd0, bus.done}, 32'd0);

        // MTHI blocked by a simultaneous flush.
        bus.start = 1'b1;
        bus.md_op = 3'd4;
        bus.valA  = 32'h1111_1111;
        bus.flush = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.flush = 1'b0;
        check("flushed mthi", bus.hi, 32'hDEAD_BEEF);

        // MULT 5x7 flushed at T+10.
        issue(3'd0, 32'd5, 32'd7);
        repeat (9) @(negedge clk);
        check("pre-flush busy", {31'd0, bus.busy}, 32'd1);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check("flush busy", {31'd0, bus.busy}, 32'd0);
        check("flush done", {31'd0, bus.done}, 32'd0);
        check("flush hi", bus.hi, 32'hDEAD_BEEF);
        check("flush lo", bus.lo, 32'h0BAD_F00D);

        // Issued at F+1; starts at T+5 and T+20 must be ignored.
        e.hi = 32'd0;
        e.lo = 32'd12;
        sb.push_back(e);
        issue(3'd0, 32'd3, 32'd4);
        waitDone("mult 3x4 pokes", 5, 20);

        runOp(vecs[1]);

        // Asynchronous reset in the middle of a run.
        issue(3'd0, 32'd5, 32'd7);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async rst busy", {31'd0, bus.busy}, 32'd0);
        check("async rst done", {31'd0, bus.done}, 32'd0);
        check("async rst hi", bus.hi, 32'd0);
        check("async rst lo", bus.lo, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        runOp(vecs[2]);

        check("scoreboard drained", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
